// File: rtl/stereo_echo.sv
// Stereo feedback echo: each left/right pair is mixed with a delayed copy from a
// circular buffer held in one single-port RAM, with signed saturation on both paths.
module stereo_echo #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int MIX_SH = 1,
  parameter int FB_SH  = 1
) (
  input  logic              sclk_in,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  left_in,
  input  logic [WIDTH-1:0]  right_in,
  input  logic [ADDR_W-1:0] delay_len,
  output logic              out_valid,
  output logic [WIDTH-1:0]  left_out,
  output logic [WIDTH-1:0]  right_out,
  output logic              ready,
  output logic              drop_err
);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_RD_L, S_MIX_L, S_RD_R, S_MIX_R, S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W:0]    clr_cnt_reg;
  logic [ADDR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic               bypass_reg;
  logic [WIDTH-1:0]   in_reg [2];
  logic [WIDTH-1:0]   y_l_reg, left_out_reg, right_out_reg;
  logic               out_valid_reg, drop_err_reg;

  logic [WIDTH-1:0]   mem [2*DEPTH];
  logic [WIDTH-1:0]   rd_data_reg;
  logic [ADDR_W:0]    ram_addr;
  logic               ram_we;
  logic [WIDTH-1:0]   ram_wdata;

  logic               accept;
  logic signed [WIDTH-1:0] d_s, d_mix, d_fb;
  logic [WIDTH-1:0]   in_cur, y_cur, w_cur;

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (sum[WIDTH] != sum[WIDTH-1])
      sat_add = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      sat_add = sum[WIDTH-1:0];
  endfunction

  assign ready  = (state_reg == S_IDLE);
  assign accept = ready && in_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cap
      always_ff @(posedge sclk_in) begin
        if (rst)
          in_reg[gi] <= '0;
        else if (accept)
          in_reg[gi] <= (gi == 0) ? left_in : right_in;
      end
    end
  endgenerate

  // One mixing datapath shared by both channels; MIX_R selects the right input.
  assign in_cur = (state_reg == S_MIX_R) ? in_reg[1] : in_reg[0];
  assign d_s    = rd_data_reg;
  assign d_mix  = d_s >>> MIX_SH;
  assign d_fb   = d_s >>> FB_SH;
  assign y_cur  = bypass_reg ? in_cur : sat_add(in_cur, d_mix);
  assign w_cur  = bypass_reg ? in_cur : sat_add(in_cur, d_fb);

  always_comb begin
    state_next = state_reg;
    ram_addr   = {1'b0, rd_ptr_reg};
    ram_we     = 1'b0;
    ram_wdata  = w_cur;
    case (state_reg)
      S_CLEAR: begin
        ram_addr  = clr_cnt_reg;
        ram_we    = 1'b1;
        ram_wdata = '0;
        if (clr_cnt_reg == '1) state_next = S_IDLE;
      end
      S_IDLE:  if (in_valid) state_next = S_RD_L;
      S_RD_L:  begin ram_addr = {1'b0, rd_ptr_reg}; state_next = S_MIX_L; end
      S_MIX_L: begin ram_addr = {1'b0, wr_ptr_reg}; ram_we = 1'b1; state_next = S_RD_R; end
      S_RD_R:  begin ram_addr = {1'b1, rd_ptr_reg}; state_next = S_MIX_R; end
      S_MIX_R: begin ram_addr = {1'b1, wr_ptr_reg}; ram_we = 1'b1; state_next = S_DONE; end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge sclk_in) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd_data_reg <= mem[ram_addr];
  end

  always_ff @(posedge sclk_in) begin
    if (rst) begin
      state_reg     <= S_CLEAR;
      clr_cnt_reg   <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      bypass_reg    <= 1'b0;
      y_l_reg       <= '0;
      left_out_reg  <= '0;
      right_out_reg <= '0;
      out_valid_reg <= 1'b0;
      drop_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= (state_reg == S_MIX_R);
      if (state_reg == S_CLEAR) clr_cnt_reg <= clr_cnt_reg + (ADDR_W+1)'(1);
      if (in_valid && !ready) drop_err_reg <= 1'b1;
      if (accept) begin
        rd_ptr_reg <= wr_ptr_reg - delay_len;
        bypass_reg <= (delay_len == '0);
      end
      if (state_reg == S_MIX_L) y_l_reg <= y_cur;
      // Outputs load on the edge into DONE so they are valid while out_valid is high.
      if (state_reg == S_MIX_R) begin
        left_out_reg  <= y_l_reg;
        right_out_reg <= y_cur;
      end
      if (state_reg == S_DONE) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
    end
  end

  assign out_valid = out_valid_reg;
  assign left_out  = left_out_reg;
  assign right_out = right_out_reg;
  assign drop_err  = drop_err_reg;

endmodule

// File: tb/tb_stereo_echo.sv
// Directed bench for stereo_echo at DEPTH=16: clear timing, impulse echoes,
// saturation, bypass, pointer wrap, busy drops and mid-pass reset.
module tb_stereo_echo;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              sclk_in = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [WIDTH-1:0]  left_in = '0;
  logic [WIDTH-1:0]  right_in = '0;
  logic [ADDR_W-1:0] delay_len = '0;
  logic              out_valid;
  logic [WIDTH-1:0]  left_out, right_out;
  logic              ready, drop_err;

  int n_checks = 0;
  int n_errors = 0;

  stereo_echo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MIX_SH(1), .FB_SH(1)) dut (
    .sclk_in(sclk_in), .rst(rst), .in_valid(in_valid),
    .left_in(left_in), .right_in(right_in), .delay_len(delay_len),
    .out_valid(out_valid), .left_out(left_out), .right_out(right_out),
    .ready(ready), .drop_err(drop_err)
  );

  always #5 sclk_in = ~sclk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    int n = 0;
    int ov = 0;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge sclk_in);
    @(negedge sclk_in);
    rst = 1'b0;
    while (!ready && n < 200) begin
      if (out_valid) ov++;
      n++;
      @(negedge sclk_in);
    end
    check({tag, " clear_cycles"}, n, 32);
    check({tag, " out_valid_during_reset"}, ov, 0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " left_out"}, left_out, 0);
    check({tag, " right_out"}, right_out, 0);
    check({tag, " drop_err"}, drop_err, 0);
    $display("%s: reset done, ready after %0d cycles", tag, n);
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!ready && k < 100) begin
      @(negedge sclk_in);
      k++;
    end
    check({tag, " ready"}, ready, 1);
  endtask

  task automatic start_pair(input string tag, input logic [WIDTH-1:0] l,
                            input logic [WIDTH-1:0] r, input logic [ADDR_W-1:0] d);
    wait_ready(tag);
    left_in   = l;
    right_in  = r;
    delay_len = d;
    in_valid  = 1'b1;
    @(negedge sclk_in);
    in_valid  = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int lat,
                          input logic [WIDTH-1:0] el, input logic [WIDTH-1:0] er);
    int k = 0;
    do begin
      @(negedge sclk_in);
      k++;
    end while (!out_valid && k < 20);
    check({tag, " latency"}, k, lat);
    check({tag, " left"}, left_out, el);
    check({tag, " right"}, right_out, er);
    $display("%s: L=%04h R=%04h (exp %04h %04h) lat=%0d", tag, left_out, right_out, el, er, k);
    @(negedge sclk_in);
    check({tag, " pulse"}, out_valid, 0);
  endtask

  // Single left impulse of 0x4000 followed by zeros; each echo halves.
  task automatic run_impulse(input string tag, input int dly, input int npairs);
    logic [WIDTH-1:0] l, el;
    for (int n = 0; n < npairs; n++) begin
      l  = (n == 0) ? 16'h4000 : 16'h0000;
      el = (n % dly == 0) ? WIDTH'(16'h4000 >> (n / dly)) : 16'h0000;
      start_pair($sformatf("%s%0d", tag, n), l, 16'h0000, ADDR_W'(dly));
      wait_out($sformatf("%s%0d", tag, n), 4, el, 16'h0000);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] rl, rr;
    @(negedge sclk_in);
    do_reset("rst0");
    run_impulse("imp", 4, 16);

    do_reset("rst1");
    start_pair("sat0", 16'h7000, 16'h9000, 4'd1);
    wait_out("sat0", 4, 16'h7000, 16'h9000);
    start_pair("sat1", 16'h7000, 16'h9000, 4'd1);
    wait_out("sat1", 4, 16'h7FFF, 16'h8000);
    start_pair("sat2", 16'h0000, 16'h0000, 4'd1);
    wait_out("sat2", 4, 16'h3FFF, 16'hC000);

    for (int i = 0; i < 40; i++) begin
      rl = WIDTH'($urandom);
      rr = WIDTH'($urandom);
      start_pair($sformatf("byp%0d", i), rl, rr, 4'd0);
      wait_out($sformatf("byp%0d", i), 4, rl, rr);
    end

    do_reset("rst2");
    run_impulse("wrap", 15, 40);

    do_reset("rst3");
    start_pair("busy0", 16'h1234, 16'h5678, 4'd0);
    @(negedge sclk_in);
    left_in  = 16'h1111;
    right_in = 16'h2222;
    in_valid = 1'b1;
    @(negedge sclk_in);
    in_valid = 1'b0;
    wait_out("busy0", 2, 16'h1234, 16'h5678);
    check("busy0 drop_err", drop_err, 1);
    start_pair("busy1", 16'h2222, 16'h3333, 4'd0);
    wait_out("busy1", 4, 16'h2222, 16'h3333);
    check("busy1 drop_err", drop_err, 1);

    start_pair("mid", 16'h4000, 16'h4000, 4'd4);
    @(negedge sclk_in);
    do_reset("rst4");
    run_impulse("imp2_", 4, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
